// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM duty-cycle calculator.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } duty_state_t;

  localparam int unsigned DEF_DUTY_SCALE = 1000;
  localparam int unsigned DEF_SCALE_W    = 10;
  localparam int unsigned DEF_NUM_W      = 32 + DEF_SCALE_W;
  localparam logic [31:0] PERIOD_SAT     = 32'hFFFF_FFFF;

endpackage

// File: rtl/seq_udiv.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first.
module seq_udiv #(
  parameter int unsigned NUM_W = 42,
  parameter int unsigned DEN_W = 33
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] quotient,
  output logic [DEN_W-1:0] remainder
);

  localparam int unsigned CNT_W = $clog2(NUM_W);

  logic [NUM_W-1:0] num_sh;
  logic [DEN_W-1:0] den_q;
  logic [DEN_W-1:0] rem_q;
  logic [NUM_W-1:0] quo_q;
  logic [CNT_W-1:0] cnt;
  logic             busy_q;

  logic [DEN_W:0]   rem_sh;
  logic [DEN_W:0]   rem_nx;
  logic             q_bit;
  logic             unused_rem_msb;

  // Partial remainder is always < den, so the shifted value fits in DEN_W+1 bits.
  always_comb begin
    rem_sh = {rem_q, num_sh[NUM_W-1]};
    q_bit  = (rem_sh >= {1'b0, den_q});
    rem_nx = q_bit ? (rem_sh - {1'b0, den_q}) : rem_sh;
  end

  assign unused_rem_msb = rem_nx[DEN_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      num_sh <= '0;
      den_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      num_sh <= num;
      den_q  <= den;
      rem_q  <= '0;
      quo_q  <= '0;
      cnt    <= CNT_W'(NUM_W - 1);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      num_sh <= {num_sh[NUM_W-2:0], 1'b0};
      rem_q  <= rem_nx[DEN_W-1:0];
      quo_q  <= {quo_q[NUM_W-2:0], q_bit};
      cnt    <= cnt - 1'b1;
      if (cnt == '0) begin
        busy_q <= 1'b0;
      end
    end
  end

  // done marks the cycle in which the final step is being clocked in.
  assign done      = busy_q && (cnt == '0);
  assign busy      = busy_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/pwm_duty_calc.sv
// Turns PWM high/low tick counts into period and scaled duty cycle,
// recomputed whenever the measured pair changes.
module pwm_duty_calc
  import pwm_pkg::*;
#(
  parameter int unsigned DUTY_SCALE = DEF_DUTY_SCALE,
  parameter int unsigned SCALE_W    = DEF_SCALE_W,
  parameter int unsigned NUM_W      = DEF_NUM_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] high_count,
  input  logic [31:0] low_count,
  output logic [15:0] duty,
  output logic [31:0] period,
  output logic        period_sat,
  output logic        no_signal,
  output logic        duty_valid,
  output logic        busy
);

  localparam int unsigned DEN_W = 33;

  duty_state_t      state;
  logic [31:0]      h_q;
  logic [31:0]      l_q;
  logic [32:0]      sum_q;
  logic [32:0]      sum_c;
  logic [NUM_W-1:0] num_c;

  logic             div_start;
  logic             div_busy;
  logic             div_done;
  logic [NUM_W-1:0] div_quo;
  logic [DEN_W-1:0] div_rem;
  logic             unused_div;

  assign sum_c     = {1'b0, h_q} + {1'b0, l_q};
  assign num_c     = NUM_W'(h_q) * NUM_W'(DUTY_SCALE);
  assign div_start = (state == LOAD) && (sum_c != '0);

  seq_udiv #(
    .NUM_W (NUM_W),
    .DEN_W (DEN_W)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .num       (num_c),
    .den       (sum_c),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign unused_div = ^{div_quo[NUM_W-1:16], div_rem, div_busy};

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      h_q        <= '0;
      l_q        <= '0;
      sum_q      <= '0;
      duty       <= '0;
      period     <= '0;
      period_sat <= 1'b0;
      no_signal  <= 1'b1;
      duty_valid <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      case (state)
        IDLE: begin
          // Inputs are only compared here, so pairs arriving mid-run collapse to the newest.
          if ({high_count, low_count} != {h_q, l_q}) begin
            h_q   <= high_count;
            l_q   <= low_count;
            state <= LOAD;
          end
        end
        LOAD: begin
          sum_q <= sum_c;
          state <= (sum_c == '0) ? DONE : DIV;
        end
        DIV: begin
          if (div_done) begin
            state <= DONE;
          end
        end
        DONE: begin
          duty       <= (sum_q == '0) ? '0 : div_quo[15:0];
          period     <= sum_q[32] ? PERIOD_SAT : sum_q[31:0];
          period_sat <= sum_q[32];
          no_signal  <= (sum_q == '0);
          duty_valid <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
